// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Purpose  : NZCV flags register, condition-code evaluation and 2-entry
//            response FIFO between ALU writeback and branch resolve.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flags_we_nz,
    input  logic             flags_we_cv,
    input  logic [3:0]       flags_in,
    output logic [3:0]       flags_q,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cond,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_take,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [1:0]       c_full    = 2'd2;
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [3:0]       r_flags;
    logic [1:0]       r_count;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_take_mem;
    logic [TAG_W-1:0] r_tag_mem [2];
    logic [CNT_W-1:0] r_taken_cnt;

    logic [3:0]       w_eff;
    logic             w_n, w_z, w_c, w_v;
    logic             w_take;
    logic             w_push;
    logic             w_pop;

    // Same-cycle flag writes are merged in so a request sees the new values.
    assign w_eff[3:2] = flags_we_nz ? flags_in[3:2] : r_flags[3:2];
    assign w_eff[1:0] = flags_we_cv ? flags_in[1:0] : r_flags[1:0];
    assign {w_n, w_z, w_c, w_v} = w_eff;

    always_comb begin
        w_take = 1'b0;
        case (req_cond)
            4'd0:    w_take = w_z;
            4'd1:    w_take = !w_z;
            4'd2:    w_take = w_c;
            4'd3:    w_take = !w_c;
            4'd4:    w_take = w_n;
            4'd5:    w_take = !w_n;
            4'd6:    w_take = w_v;
            4'd7:    w_take = !w_v;
            4'd8:    w_take = w_c & !w_z;
            4'd9:    w_take = !w_c | w_z;
            4'd10:   w_take = (w_n == w_v);
            4'd11:   w_take = (w_n != w_v);
            4'd12:   w_take = !w_z & (w_n == w_v);
            4'd13:   w_take = w_z | (w_n != w_v);
            4'd14:   w_take = 1'b1;
            default: w_take = 1'b0;
        endcase
    end

    // Ready depends only on registered count: a full FIFO refuses a push
    // even when the consumer pops in the same cycle.
    assign req_ready = (r_count != c_full);
    assign rsp_valid = (r_count != 2'd0);
    assign w_push    = req_valid & req_ready;
    assign w_pop     = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= 4'd0;
        end else begin
            if (flags_we_nz) r_flags[3:2] <= flags_in[3:2];
            if (flags_we_cv) r_flags[1:0] <= flags_in[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count      <= 2'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_take_mem   <= 2'b00;
            r_tag_mem[0] <= '0;
            r_tag_mem[1] <= '0;
        end else begin
            if (w_push) begin
                r_take_mem[r_wptr] <= w_take;
                r_tag_mem[r_wptr]  <= req_tag;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= '0;
        end else if (w_push && w_take && (r_taken_cnt != c_cnt_max)) begin
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        end
    end

    assign flags_q   = r_flags;
    assign rsp_take  = r_take_mem[r_rptr];
    assign rsp_tag   = r_tag_mem[r_rptr];
    assign taken_cnt = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_unit
// Purpose  : Randomized self-checking bench for cond_unit with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    localparam int TAG_W   = 4;
    localparam int CNT_W   = 16;
    localparam int VW      = 7 + TAG_W + CNT_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flags_we_nz = 1'b0;
    logic             flags_we_cv = 1'b0;
    logic [3:0]       flags_in = 4'd0;
    logic [3:0]       flags_q;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_cond = 4'd0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic             rsp_take;
    logic [TAG_W-1:0] rsp_tag;
    logic [CNT_W-1:0] taken_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [3:0]       m_flags = 4'd0;
    logic [TAG_W:0]   m_q[$];
    int               m_cnt = 0;
    bit               m_acc = 1'b0;

    cond_unit #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .flags_we_nz(flags_we_nz), .flags_we_cv(flags_we_cv),
        .flags_in(flags_in), .flags_q(flags_q),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cond(req_cond), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_take(rsp_take), .rsp_tag(rsp_tag),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Odd codes are the complement of the preceding even code.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [TAG_W:0] h;
        h = (m_q.size() != 0) ? m_q[0] : '0;
        return {m_flags, 1'(m_q.size() != 0), 1'(m_q.size() != 2), h, CNT_W'(m_cnt)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        logic [TAG_W:0] h;
        h = rsp_valid ? {rsp_take, rsp_tag} : '0;
        return {flags_q, rsp_valid, req_ready, h, taken_cnt};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_flags = 4'd0;
        m_cnt   = 0;
        m_acc   = 1'b0;
    endtask

    // Advance one clock edge; model follows the inputs present at the edge.
    task automatic step();
        logic [3:0] eff;
        bit acc, pop, tk;
        eff = m_flags;
        if (flags_we_nz) eff[3:2] = flags_in[3:2];
        if (flags_we_cv) eff[1:0] = flags_in[1:0];
        acc = req_valid && (m_q.size() < 2);
        pop = rsp_ready && (m_q.size() > 0);
        tk  = ref_cond(req_cond, eff);
        @(posedge clk);
        #1;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_q.push_back({tk, req_tag});
            if (tk && m_cnt < CNT_MAX) m_cnt++;
        end
        m_flags = eff;
        m_acc   = acc;
    endtask

    task automatic idle_inputs();
        flags_we_nz = 1'b0;
        flags_we_cv = 1'b0;
        req_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({flags_q, rsp_valid, req_ready, rsp_take, rsp_tag, taken_cnt} !==
            {4'd0, 1'b0, 1'b1, 1'b0, {TAG_W{1'b0}}, {CNT_W{1'b0}}})
            $display("FAIL reset_state: got %h %b %b %b %h %h", flags_q, rsp_valid,
                     req_ready, rsp_take, rsp_tag, taken_cnt);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_basic();
        flags_in = 4'b0100; flags_we_nz = 1'b1; flags_we_cv = 1'b1;
        step();
        n_checks++;
        if (flags_q !== 4'b0100) $display("FAIL basic_flags: got %b expected 0100", flags_q);
        else n_pass++;
        idle_inputs();
        req_valid = 1'b1; req_cond = 4'd0; req_tag = 4'd3; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_take, rsp_tag, taken_cnt} !== {1'b1, 1'b1, 4'd3, 16'd1})
            $display("FAIL basic_rsp: got v=%b t=%b tag=%h cnt=%h expected 1 1 3 0001",
                     rsp_valid, rsp_take, rsp_tag, taken_cnt);
        else n_pass++;
        rsp_ready = 1'b1;
        step();
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL basic_drain: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_bypass();
        flags_in = 4'b0000; flags_we_nz = 1'b1; flags_we_cv = 1'b1;
        step();
        flags_in = 4'b1000; flags_we_nz = 1'b1; flags_we_cv = 1'b0;
        req_valid = 1'b1; req_cond = 4'd4; req_tag = 4'd5; rsp_ready = 1'b1;
        step();
        n_checks++;
        if ({rsp_valid, rsp_take, rsp_tag} !== {1'b1, 1'b1, 4'd5})
            $display("FAIL bypass_mi: got v=%b t=%b tag=%h expected 1 1 5", rsp_valid, rsp_take, rsp_tag);
        else n_pass++;
        req_valid = 1'b0; flags_in = 4'b0011;
        step();
        idle_inputs();
        n_checks++;
        if (flags_q !== 4'b0000) $display("FAIL bypass_cv_hold: got %b expected 0000", flags_q);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL bypass_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [TAG_W-1:0] got[$];
        int idx = 0;
        int pushes = 0;
        rsp_ready = 1'b0; req_cond = 4'd14;
        for (int cyc = 0; cyc < 8; cyc++) begin
            req_valid = (idx < 3);
            req_tag   = TAG_W'(idx + 1);
            step();
            if (m_acc) begin idx++; pushes++; end
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL bp_fill: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
            if (pushes >= 2) begin
                n_checks++;
                if ({req_ready, rsp_valid, rsp_tag} !== {1'b0, 1'b1, 4'd1})
                    $display("FAIL bp_stall: got rdy=%b v=%b tag=%h expected 0 1 1", req_ready, rsp_valid, rsp_tag);
                else n_pass++;
            end
        end
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && got.size() < 3; cyc++) begin
            req_valid = (idx < 3);
            req_tag   = TAG_W'(idx + 1);
            if (rsp_valid) got.push_back(rsp_tag);
            step();
            if (m_acc) idx++;
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL bp_drain: got %h expected %h", obs_vec(), exp_vec());
            else n_pass++;
        end
        req_valid = 1'b0;
        n_checks++;
        if (got.size() != 3 || got[0] !== 4'd1 || got[1] !== 4'd2 || got[2] !== 4'd3)
            $display("FAIL bp_order: got %p expected '{1,2,3}", got);
        else n_pass++;
        step();
    endtask

    task automatic test_sweep();
        rsp_ready = 1'b1;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                flags_in = 4'(f); flags_we_nz = 1'b1; flags_we_cv = 1'b1;
                req_valid = 1'b1; req_cond = 4'(c); req_tag = TAG_W'($urandom);
                step();
                n_checks++;
                if (obs_vec() !== exp_vec())
                    $display("FAIL sweep f=%h c=%0d: got %h expected %h", f, c, obs_vec(), exp_vec());
                else n_pass++;
                if (c >= 14) begin
                    n_checks++;
                    if (rsp_take !== (c == 14))
                        $display("FAIL sweep_fixed f=%h c=%0d: got %b", f, c, rsp_take);
                    else n_pass++;
                end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            flags_we_nz = 1'($urandom);
            flags_we_cv = 1'($urandom);
            flags_in    = 4'($urandom);
            req_valid   = 1'($urandom);
            req_cond    = 4'($urandom);
            req_tag     = TAG_W'($urandom);
            rsp_ready   = ($urandom_range(0, 3) != 0);
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL random i=%0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        idle_inputs();
        rsp_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_saturate();
        int guard = 0;
        idle_inputs();
        rsp_ready = 1'b1; req_valid = 1'b1; req_cond = 4'd14; req_tag = 4'd7;
        while (m_cnt < CNT_MAX - 1 && guard < 70000) begin
            step();
            guard++;
        end
        n_checks++;
        if (taken_cnt !== 16'hFFFE) $display("FAIL sat_preload: got %h expected fffe", taken_cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_vec() !== exp_vec()) $display("FAIL sat_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (taken_cnt !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", taken_cnt);
        else n_pass++;
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_full();
        rsp_ready = 1'b0; req_valid = 1'b1; req_cond = 4'd14; req_tag = 4'd9;
        flags_in = 4'hF; flags_we_nz = 1'b1; flags_we_cv = 1'b1;
        step();
        step();
        idle_inputs();
        n_checks++;
        if ({req_ready, rsp_valid} !== 2'b01)
            $display("FAIL rst_full_pre: got rdy=%b v=%b expected 0 1", req_ready, rsp_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready, taken_cnt} !== {1'b0, 1'b1, 16'd0})
            $display("FAIL rst_async: got v=%b rdy=%b cnt=%h expected 0 1 0000", rsp_valid, req_ready, taken_cnt);
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, flags_q} !== {1'b1, 4'd0})
            $display("FAIL rst_release: got rdy=%b flags=%b expected 1 0000", req_ready, flags_q);
        else n_pass++;
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL rst_state: got %h expected %h", obs_vec(), exp_vec());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_backpressure();
        test_sweep();
        test_random();
        test_saturate();
        test_reset_full();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_unit.md
# cond_unit

Condition-evaluation block on the consumer side of the ALU flags interface. Holds the architectural NZCV flags register, which is written from `alu_flags` results under per-group write enables. Evaluates 4-bit condition codes against those flags for branch and predication requests. Results return through a 2-entry response FIFO with valid/ready handshakes on both sides; the block sits between the ALU writeback and the fetch/branch-resolve stage.

## Interface
- `TAG_W`, 4, width of the request/response tag carried through unchanged
- `CNT_W`, 16, width of the saturating taken-event counter
- `clk` input 1 — sole clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `flags_we_nz` input 1 — update N and Z from `flags_in` this cycle
- `flags_we_cv` input 1 — update C and V from `flags_in` this cycle
- `flags_in` input 4 — `alu_flags` packed {N,Z,C,V}, bit3 = N, bit0 = V
- `flags_q` output 4 — current flags register, same packing
- `req_valid` input 1 — condition request present
- `req_ready` output 1 — block can accept a request
- `req_cond` input 4 — condition code
- `req_tag` input TAG_W — opaque tag
- `rsp_valid` output 1 — response present at FIFO head
- `rsp_ready` input 1 — consumer accepts the response
- `rsp_take` output 1 — condition true
- `rsp_tag` output TAG_W — tag of the head response
- `taken_cnt` output CNT_W — count of accepted requests whose condition evaluated true

## Operation
- Flags register: the N/Z pair loads from `flags_in[3:2]` when `flags_we_nz` is set; the C/V pair loads from `flags_in[1:0]` when `flags_we_cv` is set. The two groups are independent.
- Evaluation uses the effective flags: the register with the same-cycle write merged in. A request accepted in the same cycle as a flag write sees the new values.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Accept (push) happens when `req_valid & req_ready`. It writes {take, tag} at the FIFO tail and increments `taken_cnt` if take=1.
- Pop happens when `rsp_valid & rsp_ready`.
- FIFO: 2 entries, write pointer, read pointer and a 2-bit count.
  - States by count: EMPTY(0), ONE(1), FULL(2).
  - Push only: count +1. Pop only: count −1. Push and pop together: count unchanged.
- `req_ready` = (count != 2). It is a registered-state function and does not depend on `rsp_ready`, so a FULL FIFO refuses a push even if a pop occurs that cycle.
- `rsp_valid` = (count != 0). `rsp_take` and `rsp_tag` show the head entry and must stay stable while `rsp_valid & !rsp_ready`.
- Pointers are 1 bit each and wrap 1→0.
- `taken_cnt` saturates at all-ones and never wraps.

## Timing
- Reset (async assert, sync-release usage assumed by the system):
  - `flags_q` = 0, `rsp_valid` = 0, `req_ready` = 1.
  - `rsp_take` = 0, `rsp_tag` = 0, `taken_cnt` = 0.
  - FIFO contents and pointers are cleared.
- Reset asserted mid-operation discards all queued responses immediately; no handshake completes in that cycle.
- Flags latency: a write at edge t is visible on `flags_q` after edge t.
- Request-to-response latency is 1 cycle when EMPTY: accepted at edge t, `rsp_valid` = 1 after edge t.
- Throughput is one request per cycle while the consumer drains every cycle (steady state ONE).
- The counter updates on the same edge as the accepting push.

## Test plan
- Reset, then `flags_in`=4'b0100 with both write enables set; next cycle request cond=0 (EQ) tag=3 → `flags_q`=4'b0100, one cycle later `rsp_valid`=1, `rsp_take`=1, `rsp_tag`=3, `taken_cnt`=1.
- Same-cycle bypass: `flags_q`=0; write `flags_in`=4'b1000 with `flags_we_nz` only while requesting cond=4 (MI) → `rsp_take`=1. With `flags_in`=4'b0011 and `flags_we_nz` only, C/V stay 0.
- Backpressure: `rsp_ready`=0 and three back-to-back requests with tags 1, 2, 3 → tags 1 and 2 accepted, `req_ready`=0 after the second push, tag 3 held. With `rsp_ready`=1, responses pop in order 1, 2, 3 and outputs are stable while stalled.
- Sweep all 16 condition codes over all 16 NZCV values → `rsp_take` matches the condition table above for all 256 cases; cond 14 is always 1, cond 15 always 0.
- Saturation: preload so that `taken_cnt`=0xFFFE, issue three AL requests → `taken_cnt` = 0xFFFF and holds.
- Assert `rst_n` with the FIFO FULL → `rsp_valid` drops to 0 asynchronously; after release `req_ready`=1 and `flags_q`=0.
